// File: rtl/mips_run_monitor.sv
// mips_run_monitor: supervises one program run of mips_cpu_harvard.
// Watches for the CPU to start, counts run length, detects the halt,
// checks that fetching stops after the halt and compares the final $v0
// against a reference, producing a single sticky pass/fail verdict.
//
// Handshake: there is no valid/ready pair here. The monitor samples its
// inputs on every rising edge where clk_enable=1 (the same qualifier the
// CPU uses) and ignores them entirely when clk_enable=0. The verdict
// (done/pass/fail_code) is a level that stays asserted until reset.
module mips_run_monitor #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int START_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 1,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             active,
    input  logic [31:0]      register_v0,
    input  logic [31:0]      instr_address,
    input  logic [31:0]      expected_v0,
    output logic             done,
    output logic             pass,
    output logic [2:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [31:0]      final_v0,
    output logic [31:0]      halt_address
);

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_NO_START = 3'd1;
    localparam logic [2:0] FC_TIMEOUT  = 3'd2;
    localparam logic [2:0] FC_FETCH    = 3'd3;
    localparam logic [2:0] FC_V0       = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]      START_LIM   = 32'(START_CYCLES);
    localparam logic [31:0]      SETTLE_LIM  = 32'(SETTLE_CYCLES);

    // FSM state is kept as a named signal so checkers can bind to it.
    state_t      state;
    logic [31:0] start_cnt;
    logic [31:0] settle_cnt;

    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      start_inc;
    logic [31:0]      settle_inc;
    logic [2:0]       v0_code;
    logic             pc_moved;

    // Next-value helpers: saturating run counter, phase counters, v0 verdict.
    always_comb begin
        cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + CNT_ONE;
        start_inc  = start_cnt + 32'd1;
        settle_inc = settle_cnt + 32'd1;
        v0_code    = (final_v0 != expected_v0) ? FC_V0 : FC_NONE;
        pc_moved   = (instr_address != halt_address);
    end

    // Supervision FSM with registered verdict, counters and halt captures.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_START;
            start_cnt    <= 32'd0;
            settle_cnt   <= 32'd0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_code    <= FC_NONE;
            cycle_count  <= '0;
            final_v0     <= 32'd0;
            halt_address <= 32'd0;
        end else if (clk_enable) begin
            case (state)
                ST_START: begin
                    if (active) begin
                        // The edge that first sees active=1 is itself a
                        // run cycle, so a one-edge program reports 1.
                        cycle_count <= CNT_ONE;
                        if (CNT_ONE >= TIMEOUT_LIM) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            pass      <= 1'b0;
                            fail_code <= FC_TIMEOUT;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        start_cnt <= start_inc;
                        if (start_inc >= START_LIM) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            pass      <= 1'b0;
                            fail_code <= FC_NO_START;
                        end
                    end
                end

                ST_RUN: begin
                    // Timeout wins over a halt sampled on the same edge.
                    if ((active && (cnt_inc >= TIMEOUT_LIM)) ||
                        (cycle_count >= TIMEOUT_LIM)) begin
                        if (active) begin
                            cycle_count <= cnt_inc;
                        end
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_code <= FC_TIMEOUT;
                    end else if (active) begin
                        cycle_count <= cnt_inc;
                    end else begin
                        final_v0     <= register_v0;
                        halt_address <= instr_address;
                        settle_cnt   <= 32'd0;
                        state        <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (pc_moved || active) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        pass      <= 1'b0;
                        fail_code <= FC_FETCH;
                    end else begin
                        settle_cnt <= settle_inc;
                        if (settle_inc >= SETTLE_LIM) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            pass      <= (v0_code == FC_NONE);
                            fail_code <= v0_code;
                        end
                    end
                end

                default: begin
                    // DONE is sticky until reset; inputs are ignored.
                    state <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor. Each run is described by a few numbers
// (idle edges before start, active edges, settle behaviour, halt values);
// the expected verdict and its enabled-edge index come from those numbers.
module tb_mips_run_monitor;

    localparam int TIMEOUT = 16;
    localparam int START   = 2;
    localparam int SETTLE  = 1;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic        active = 1'b0;
    logic [31:0] register_v0 = 32'd0;
    logic [31:0] instr_address = 32'd0;
    logic [31:0] expected_v0 = 32'd0;
    logic        done;
    logic        pass;
    logic [2:0]  fail_code;
    logic [31:0] cycle_count;
    logic [31:0] final_v0;
    logic [31:0] halt_address;

    always #5 clk = ~clk;

    mips_run_monitor #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .START_CYCLES   (START),
        .SETTLE_CYCLES  (SETTLE),
        .CNT_W          (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .active        (active),
        .register_v0   (register_v0),
        .instr_address (instr_address),
        .expected_v0   (expected_v0),
        .done          (done),
        .pass          (pass),
        .fail_code     (fail_code),
        .cycle_count   (cycle_count),
        .final_v0      (final_v0),
        .halt_address  (halt_address)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_pass"},  {31'd0, pass}, 32'd0);
        check({tag, "_fcode"}, {29'd0, fail_code}, 32'd0);
        check({tag, "_count"}, cycle_count, 32'd0);
        check({tag, "_v0"},    final_v0, 32'd0);
        check({tag, "_haddr"}, halt_address, 32'd0);
    endtask

    // ---------------- driver + reference model ----------------
    // d: idle edges before active rises, n: active edges,
    // mode: 0 clean settle, 1 PC steps after halt, 2 active re-rises.
    task automatic run_case(input int d, input int n, input int mode,
                            input logic [31:0] v0_halt, input logic [31:0] exp_v0,
                            input logic [31:0] halt_pc, input bit gaps, input int abort_at);
        int e_edge;
        logic [31:0] ef, ec, ev, eh;
        logic [31:0] rf, rc, rv, rh;

        // Expected outcome straight from the run description.
        if (d >= START) begin
            e_edge = START; ef = 1; ec = 0; ev = 0; eh = 0;
        end else if (n >= TIMEOUT) begin
            e_edge = d + TIMEOUT; ef = 2; ec = TIMEOUT; ev = 0; eh = 0;
        end else begin
            e_edge = d + n + 1 + SETTLE;
            ec = n; ev = v0_halt; eh = halt_pc;
            if (mode != 0) ef = 3;
            else if (v0_halt != exp_v0) ef = 4;
            else ef = 0;
        end
        exp_q.push_back(ef);
        exp_q.push_back(ec);
        exp_q.push_back(ev);
        exp_q.push_back(eh);
        rf = ef; rc = ec; rv = ev; rh = eh;

        reset = 1'b0;
        clk_enable = 1'($urandom_range(0, 1));
        active = 1'b0;
        expected_v0 = exp_v0;
        tick();
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int k = 1; k <= e_edge + 10; k++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    clk_enable    = 1'b0;
                    active        = 1'($urandom_range(0, 1));
                    register_v0   = $urandom;
                    instr_address = $urandom;
                    tick();
                    check("gap_done_hold", {31'd0, done}, (k - 1 >= e_edge) ? 32'd1 : 32'd0);
                end
            end
            clk_enable  = 1'b1;
            register_v0 = $urandom;
            if (k > e_edge) begin
                active        = 1'($urandom_range(0, 1));
                instr_address = $urandom;
            end else if (k <= d) begin
                active        = 1'b0;
                instr_address = 32'hBFC0_0000;
            end else if (k <= d + n) begin
                active        = 1'b1;
                instr_address = $urandom;
            end else if (k == d + n + 1) begin
                active        = 1'b0;
                instr_address = halt_pc;
                register_v0   = v0_halt;
            end else begin
                active        = (mode == 2);
                instr_address = (mode == 1) ? halt_pc + 32'd4 : halt_pc;
            end
            tick();

            if (k < e_edge) begin
                check("not_done", {31'd0, done}, 32'd0);
                if (k > d && k <= d + n)
                    check("run_count", cycle_count, 32'(k - d));
            end else if (k == e_edge) begin
                ef = exp_q.pop_front();
                ec = exp_q.pop_front();
                ev = exp_q.pop_front();
                eh = exp_q.pop_front();
                check("done",      {31'd0, done}, 32'd1);
                check("pass",      {31'd0, pass}, (ef == 0) ? 32'd1 : 32'd0);
                check("fail_code", {29'd0, fail_code}, ef);
                check("count",     cycle_count, ec);
                check("final_v0",  final_v0, ev);
                check("halt_addr", halt_address, eh);
            end else begin
                check("hold_done",  {31'd0, done}, 32'd1);
                check("hold_fcode", {29'd0, fail_code}, rf);
                check("hold_count", cycle_count, rc);
                check("hold_v0",    final_v0, rv);
                check("hold_haddr", halt_address, rh);
            end

            if (abort_at != 0 && k == abort_at) begin
                #2;
                reset = 1'b0;
                #1;
                check_all_zero("async_reset");
                exp_q.delete();
                return;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Directed runs from the test plan.
        run_case(0, 5, 0, 32'h0000_0042, 32'h0000_0042, 32'hBFC0_0020, 1'b0, 0);
        run_case(0, 5, 0, 32'h0000_0042, 32'h0000_0043, 32'hBFC0_0020, 1'b0, 0);
        run_case(2, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        run_case(0, 40, 0, 32'h1, 32'h1, 32'h0, 1'b0, 0);
        run_case(0, 3, 1, 32'h7, 32'h7, 32'hBFC0_0010, 1'b0, 0);
        run_case(0, 3, 2, 32'h7, 32'h7, 32'hBFC0_0010, 1'b0, 0);
        run_case(1, 1, 0, 32'h9, 32'h9, 32'hBFC0_0004, 1'b0, 0);
        run_case(0, 12, 0, 32'h42, 32'h42, 32'hBFC0_0030, 1'b1, 0);
        run_case(0, 30, 0, 32'h42, 32'h42, 32'hBFC0_0030, 1'b1, 6);
        run_case(1, 15, 0, 32'h5, 32'h5, 32'hBFC0_0040, 1'b0, 0);

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            int d, n, mode;
            logic [31:0] v0h, ev0, pc;
            d    = ($urandom_range(0, 5) == 0) ? 2 : $urandom_range(0, 1);
            n    = $urandom_range(1, 20);
            mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            v0h  = $urandom;
            ev0  = ($urandom_range(0, 2) == 0) ? $urandom : v0h;
            pc   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            run_case(d, n, mode, v0h, ev0, pc, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
